pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 39 +++
 rtl/pipe_hazard_ctrl_if.sv | 55 +++++
 rtl/pipe_fwd_unit.sv | 48 ++++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_hazard_ctrl_pkg                                          |
// | Purpose  : Shared types and constants for the pipeline hazard controller:|
// |            FSM state encoding, forwarding select codes, the hard-wired   |
// |            zero register, event-counter width and a register-match      |
// |            helper used by the forwarding unit.                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } hz_state_t;

  // ALU operand source select
  localparam logic [1:0] c_fwd_rf    = 2'b00;
  localparam logic [1:0] c_fwd_exmem = 2'b10;
  localparam logic [1:0] c_fwd_memwb = 2'b01;

  localparam logic [4:0] c_reg_zero = 5'd0;

  localparam int                   c_cnt_w   = 16;
  localparam logic [c_cnt_w-1:0]   c_cnt_max = {c_cnt_w{1'b1}};
  localparam logic [c_cnt_w-1:0]   c_cnt_one = {{(c_cnt_w-1){1'b0}}, 1'b1};

  // A producer matches a consumer source only when it actually writes,
  // targets a real register (r0 is never written) and the source is read.
  function automatic logic reg_match(input logic       we,
                                     input logic [4:0] rd,
                                     input logic       uses,
                                     input logic [4:0] src);
    return we && (rd != c_reg_zero) && uses && (rd == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_hazard_ctrl_if                                           |
// | Purpose  : Bundle of pipeline-stage status inputs and hazard control     |
// |            outputs of the hazard controller.                             |
// |            master : pipeline side (drives stage fields, receives control)|
// |            slave  : hazard controller side                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  // ID stage sources
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               id_uses_rs;
  logic               id_uses_rt;
  // ID/EX, EX/MEM, MEM/WB producers
  logic [4:0]         ex_rd;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic [4:0]         mem_rd;
  logic               mem_reg_write;
  logic [4:0]         wb_rd;
  logic               wb_reg_write;
  logic               ex_branch_taken;
  // Control outputs
  logic               pc_stall;
  logic               if_id_stall;
  logic               if_id_flush;
  logic               id_ex_bubble;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;
  logic [1:0]         hz_state;
  logic [c_cnt_w-1:0] stall_count;
  logic [c_cnt_w-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_rd, ex_reg_write, ex_mem_read,
    output mem_rd, mem_reg_write, wb_rd, wb_reg_write, ex_branch_taken,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
    input  fwd_a, fwd_b, hz_state, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_rd, ex_reg_write, ex_mem_read,
    input  mem_rd, mem_reg_write, wb_rd, wb_reg_write, ex_branch_taken,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
    output fwd_a, fwd_b, hz_state, stall_count, flush_count
  );

endinterface
`default_nettype wire

// File: rtl/pipe_fwd_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_fwd_unit                                                 |
// | Purpose  : Per-operand source matching against the ID/EX, EX/MEM and     |
// |            MEM/WB producers, plus the forwarding select for that operand.|
// | Ports    : i_src/i_uses       - source register and its read flag        |
// |            i_ex_* / i_mem_* / i_wb_* - producer destination and enables  |
// |            o_fwd              - 00 RF, 10 EX/MEM, 01 MEM/WB              |
// |            o_ex_hit/o_mem_hit - source matches ID/EX / EX/MEM producer   |
// |            o_load_use         - source matches a load sitting in ID/EX   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipe_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_uses,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_reg_write,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_reg_write,
  output logic [1:0] o_fwd,
  output logic       o_ex_hit,
  output logic       o_mem_hit,
  output logic       o_load_use
);

  logic w_wb_hit;

  assign o_ex_hit   = reg_match(i_ex_reg_write,  i_ex_rd,  i_uses, i_src);
  assign o_mem_hit  = reg_match(i_mem_reg_write, i_mem_rd, i_uses, i_src);
  assign w_wb_hit   = reg_match(i_wb_reg_write,  i_wb_rd,  i_uses, i_src);
  assign o_load_use = o_ex_hit & i_ex_mem_read;

  // EX/MEM holds the younger value, so it wins over MEM/WB.
  always_comb begin
    o_fwd = c_fwd_rf;
    if (o_mem_hit)
      o_fwd = c_fwd_exmem;
    else if (w_wb_hit)
      o_fwd = c_fwd_memwb;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_hazard_ctrl                                              |
// | Purpose  : Hazard control for a 5-stage pipeline: load-use / RAW stall,  |
// |            branch flush, operand forwarding select and event counters.   |
// | Ports    : clk, reset (async, active-high)                                |
// |            hz : pipe_hazard_ctrl_if.slave (stage status in, control out) |
// | Config   : HAZARD_FWD_EN defined   - forwarding active, only load-use    |
// |                                      stalls                              |
// |            HAZARD_FWD_EN undefined - fwd_a/fwd_b = 00, any ID/EX or      |
// |                                      EX/MEM match stalls                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  hz_state_t          r_state;
  hz_state_t          w_next;
  logic [c_cnt_w-1:0] r_stall_cnt;
  logic [c_cnt_w-1:0] r_flush_cnt;

  logic [1:0] w_fwd_a, w_fwd_b, w_fwd_sel_a, w_fwd_sel_b;
  logic       w_ld_a, w_ld_b, w_ex_a, w_ex_b, w_mem_a, w_mem_b;
  logic       w_hazard;
  logic       w_stall, w_flush, w_bubble;

  pipe_fwd_unit u_fwd_a (
    .i_src           (hz.id_rs),
    .i_uses          (hz.id_uses_rs),
    .i_ex_rd         (hz.ex_rd),
    .i_ex_reg_write  (hz.ex_reg_write),
    .i_ex_mem_read   (hz.ex_mem_read),
    .i_mem_rd        (hz.mem_rd),
    .i_mem_reg_write (hz.mem_reg_write),
    .i_wb_rd         (hz.wb_rd),
    .i_wb_reg_write  (hz.wb_reg_write),
    .o_fwd           (w_fwd_a),
    .o_ex_hit        (w_ex_a),
    .o_mem_hit       (w_mem_a),
    .o_load_use      (w_ld_a)
  );

  pipe_fwd_unit u_fwd_b (
    .i_src           (hz.id_rt),
    .i_uses          (hz.id_uses_rt),
    .i_ex_rd         (hz.ex_rd),
    .i_ex_reg_write  (hz.ex_reg_write),
    .i_ex_mem_read   (hz.ex_mem_read),
    .i_mem_rd        (hz.mem_rd),
    .i_mem_reg_write (hz.mem_reg_write),
    .i_wb_rd         (hz.wb_rd),
    .i_wb_reg_write  (hz.wb_reg_write),
    .o_fwd           (w_fwd_b),
    .o_ex_hit        (w_ex_b),
    .o_mem_hit       (w_mem_b),
    .o_load_use      (w_ld_b)
  );

`ifdef HAZARD_FWD_EN
  // Bypass covers every RAW case except a load whose data is not yet read.
  logic w_unused_hits;
  assign w_unused_hits = ^{w_ex_a, w_ex_b, w_mem_a, w_mem_b};
  assign w_hazard      = w_ld_a | w_ld_b;
  assign w_fwd_sel_a   = w_fwd_a;
  assign w_fwd_sel_b   = w_fwd_b;
`else
  // No bypass: wait until the producer has left EX/MEM; the register file
  // is assumed write-before-read for the MEM/WB producer.
  logic w_unused_fwd;
  assign w_unused_fwd  = ^{w_fwd_a, w_fwd_b, w_ld_a, w_ld_b};
  assign w_hazard      = w_ex_a | w_ex_b | w_mem_a | w_mem_b;
  assign w_fwd_sel_a   = c_fwd_rf;
  assign w_fwd_sel_b   = c_fwd_rf;
`endif

  // Mealy control: outputs settle in the first half of the cycle so the
  // pipeline registers see them at their negedge capture.
  always_comb begin
    w_next   = r_state;
    w_stall  = 1'b0;
    w_flush  = 1'b0;
    w_bubble = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (hz.ex_branch_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
          w_next   = ST_FLUSH;
        end else if (w_hazard) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
          w_next   = ST_HOLD;
        end
      end
      ST_FLUSH: begin
        w_bubble = 1'b1;
        w_next   = ST_RUN;
      end
      ST_HOLD: begin
        if (w_hazard) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end else begin
          w_next   = ST_RUN;
        end
      end
      default: w_next = ST_RUN;
    endcase
    if (reset) begin
      w_next   = ST_RUN;
      w_stall  = 1'b0;
      w_flush  = 1'b0;
      w_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_stall && (r_stall_cnt != c_cnt_max))
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      if (w_flush && (r_flush_cnt != c_cnt_max))
        r_flush_cnt <= r_flush_cnt + c_cnt_one;
    end
  end

  assign hz.pc_stall     = w_stall;
  assign hz.if_id_stall  = w_stall;
  assign hz.if_id_flush  = w_flush;
  assign hz.id_ex_bubble = w_bubble;
  assign hz.fwd_a        = reset ? c_fwd_rf : w_fwd_sel_a;
  assign hz.fwd_b        = reset ? c_fwd_rf : w_fwd_sel_b;
  assign hz.hz_state     = r_state;
  assign hz.stall_count  = r_stall_cnt;
  assign hz.flush_count  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipe_hazard_ctrl                                           |
// | Purpose  : Self-checking bench for pipe_hazard_ctrl. Table vectors from  |
// |            RUN plus multi-cycle sequences; expected control outputs go   |
// |            through a scoreboard queue checked on the falling edge.       |
// |            Expectations follow HAZARD_FWD_EN when it is defined.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif
  localparam logic NF = ~FWD;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz_if();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  typedef struct packed {
    logic [4:0] rs;    logic urs;
    logic [4:0] rt;    logic urt;
    logic [4:0] exrd;  logic exw; logic exm;
    logic [4:0] memrd; logic memw;
    logic [4:0] wbrd;  logic wbw;
    logic       br;
  } in_t;

  typedef struct packed {
    logic [127:0] name;
    logic         stall;
    logic         flush;
    logic         bubble;
    logic [1:0]   fa;
    logic [1:0]   fb;
    logic [1:0]   st;
  } exp_t;

  typedef struct packed { in_t i; exp_t e; } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  exp_t sb_q [$];
  exp_t e_chk;
  logic [8:0] got_v, want_v;
  int checks   = 0;
  int failures = 0;

  function automatic in_t vin(input logic [4:0] rs, input logic urs,
                              input logic [4:0] rt, input logic urt,
                              input logic [4:0] exrd, input logic exw, input logic exm,
                              input logic [4:0] memrd, input logic memw,
                              input logic [4:0] wbrd, input logic wbw,
                              input logic br);
    in_t v;
    v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
    v.exrd = exrd; v.exw = exw; v.exm = exm;
    v.memrd = memrd; v.memw = memw; v.wbrd = wbrd; v.wbw = wbw; v.br = br;
    return v;
  endfunction

  function automatic exp_t vex(input logic [127:0] n, input logic s, input logic f,
                               input logic b, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [1:0] st);
    exp_t e;
    e.name = n; e.stall = s; e.flush = f; e.bubble = b;
    e.fa = fa; e.fb = fb; e.st = st;
    return e;
  endfunction

  task automatic apply(input in_t v);
    hz_if.id_rs = v.rs;        hz_if.id_uses_rs = v.urs;
    hz_if.id_rt = v.rt;        hz_if.id_uses_rt = v.urt;
    hz_if.ex_rd = v.exrd;      hz_if.ex_reg_write = v.exw;
    hz_if.ex_mem_read = v.exm; hz_if.mem_rd = v.memrd;
    hz_if.mem_reg_write = v.memw;
    hz_if.wb_rd = v.wbrd;      hz_if.wb_reg_write = v.wbw;
    hz_if.ex_branch_taken = v.br;
  endtask

  // Drive one cycle's inputs and queue the outputs expected for that cycle.
  task automatic drive(input in_t v, input exp_t e);
    apply(v);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [127:0] n, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %0s got=%h want=%h", n, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply('0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard checker: mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      e_chk  = sb_q.pop_front();
      got_v  = {hz_if.pc_stall, hz_if.if_id_stall, hz_if.if_id_flush,
                hz_if.id_ex_bubble, hz_if.fwd_a, hz_if.fwd_b, hz_if.hz_state};
      want_v = {e_chk.stall, e_chk.stall, e_chk.flush, e_chk.bubble,
                e_chk.fa, e_chk.fb, e_chk.st};
      checks++;
      if (got_v !== want_v) begin
        failures++;
        $display("FAIL %0s got=%b want=%b (stall,ifid_stall,flush,bubble,fa,fb,state)",
                 e_chk.name, got_v, want_v);
      end
    end
  end

  in_t idle, lu5, brlu, br_only, nasty;

  initial begin
    idle    = '0;
    lu5     = vin(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    brlu    = lu5;
    brlu.br = 1'b1;
    br_only = vin(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    nasty   = vin(5'd5, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1);

    // Single-cycle vectors, each applied from RUN straight after reset.
    vecs[0]  = {idle, vex("idle", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0)};
    vecs[1]  = {lu5,  vex("lu_rs", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'd0)};
    vecs[2]  = {vin(5'd0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0),
                vex("lu_rt", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'd0)};
    vecs[3]  = {vin(5'd5, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0),
                vex("lu_unused", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0)};
    vecs[4]  = {vin(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0),
                vex("lu_r0", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0)};
    vecs[5]  = {vin(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0),
                vex("lu_no_we", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0)};
    vecs[6]  = {vin(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0),
                vex("ex_alu", NF, 1'b0, NF, 2'b00, 2'b00, 2'd0)};
    vecs[7]  = {vin(5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0),
                vex("mem_rt", NF, 1'b0, NF, 2'b00, FWD ? 2'b10 : 2'b00, 2'd0)};
    vecs[8]  = {vin(5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0),
                vex("mem_wb_prio", NF, 1'b0, NF, 2'b00, FWD ? 2'b10 : 2'b00, 2'd0)};
    vecs[9]  = {vin(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0),
                vex("wb_rs", 1'b0, 1'b0, 1'b0, FWD ? 2'b01 : 2'b00, 2'b00, 2'd0)};
    vecs[10] = {vin(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0),
                vex("fwd_r0", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0)};
    vecs[11] = {br_only, vex("branch", 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'd0)};
    vecs[12] = {brlu,    vex("branch_lu", 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'd0)};
    vecs[13] = {vin(5'd2, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0),
                vex("fwd_a_b", NF, 1'b0, NF, FWD ? 2'b10 : 2'b00, FWD ? 2'b01 : 2'b00, 2'd0)};
    vecs[14] = {vin(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0),
                vex("mem_no_we", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0)};

    // Reset holds everything at zero even with hazards and branch present.
    reset = 1'b1;
    apply(nasty);
    #1;
    drive(nasty, vex("reset_out", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    chk("reset_stall_cnt", hz_if.stall_count, 16'h0000);
    chk("reset_flush_cnt", hz_if.flush_count, 16'h0000);

    for (int k = 0; k < NV; k++) begin
      do_reset();
      drive(vecs[k].i, vecs[k].e);
    end

    // Load-use followed by the load advancing down the pipe.
    do_reset();
    drive(lu5, vex("lu_c0", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'd0));
    drive(vin(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0),
          vex("lu_c1", NF, 1'b0, NF, FWD ? 2'b10 : 2'b00, 2'b00, 2'd2));
    drive(vin(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0),
          vex("lu_c2", 1'b0, 1'b0, 1'b0, FWD ? 2'b01 : 2'b00, 2'b00, FWD ? 2'd0 : 2'd2));
    chk("lu_stall_cnt", hz_if.stall_count, FWD ? 16'd1 : 16'd2);

    // ALU producer r7 advancing; stalls only without forwarding.
    do_reset();
    drive(vin(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0),
          vex("raw_c0", NF, 1'b0, NF, 2'b00, 2'b00, 2'd0));
    drive(vin(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0),
          vex("raw_c1", NF, 1'b0, NF, FWD ? 2'b10 : 2'b00, 2'b00, FWD ? 2'd0 : 2'd2));
    drive(vin(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0),
          vex("raw_c2", 1'b0, 1'b0, 1'b0, FWD ? 2'b01 : 2'b00, 2'b00, FWD ? 2'd0 : 2'd2));
    drive(idle, vex("raw_c3", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    chk("raw_stall_cnt", hz_if.stall_count, FWD ? 16'd0 : 16'd2);

    // Branch beats a concurrent load-use; FLUSH ignores branch and hazard.
    do_reset();
    drive(brlu, vex("br_c0", 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'd0));
    drive(brlu, vex("br_c1", 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'd1));
    drive(idle, vex("br_c2", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    chk("br_flush_cnt", hz_if.flush_count, 16'd1);
    chk("br_stall_cnt", hz_if.stall_count, 16'd0);

    // Reset in HOLD: takes effect without a clock edge, no residue.
    do_reset();
    drive(lu5, vex("hold_enter", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'd0));
    reset = 1'b1;
    #1;
    chk("rst_async_state", {14'd0, hz_if.hz_state}, 16'd0);
    chk("rst_async_cnt", hz_if.stall_count, 16'd0);
    drive(lu5, vex("rst_in_hold", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    reset = 1'b0;
    drive(idle, vex("post_rst_hold", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));

    // Reset in FLUSH: the pending bubble is dropped.
    do_reset();
    drive(br_only, vex("flush_enter", 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'd0));
    reset = 1'b1;
    drive(idle, vex("rst_in_flush", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    reset = 1'b0;
    drive(idle, vex("post_rst_flush", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    chk("rst_flush_cnt", hz_if.flush_count, 16'd0);

    // Sustained stall: counter reaches FFFF and stays there.
    do_reset();
    apply(lu5);
    repeat (65534) @(posedge clk);
    #1;
    chk("stall_cnt_fffe", hz_if.stall_count, 16'hFFFE);
    repeat (70000 - 65534) @(posedge clk);
    #1;
    chk("stall_cnt_sat", hz_if.stall_count, 16'hFFFF);

    apply(idle);
    @(posedge clk);
    #1;
    chk("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
